// File: rtl/laser_pkg.sv
// Shared types for the laser placement feeder/engine pair.
// Point packing matches the engine's internal {y, x} layout.
package laser_pkg;

  localparam int COORD_W     = 4;
  localparam int NUM_PTS_DEF = 40;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;

  typedef enum logic [2:0] {
    FILL,
    GAP,
    SEND,
    WAIT_DONE,
    REPORT
  } feed_state_t;

endpackage

// File: rtl/laser_pt_buf.sv
// Frame point store: one synchronous write port, one combinational read.
// Storage is deliberately unreset; every frame is rewritten before use.
module laser_pt_buf
  import laser_pkg::*;
#(
  parameter int NUM_PTS = NUM_PTS_DEF,
  parameter int AW      = $clog2(NUM_PTS)
) (
  input  logic                   CLK,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [2*COORD_W-1:0]   wdata,
  input  logic [AW-1:0]          raddr,
  output logic [2*COORD_W-1:0]   rdata
);

  logic [2*COORD_W-1:0] mem [NUM_PTS];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/laser_point_feeder.sv
// Buffers a frame of points, streams it to the placement engine,
// then reports the engine's circle centres and DONE latency.
module laser_point_feeder
  import laser_pkg::*;
#(
  parameter int NUM_PTS   = NUM_PTS_DEF,
  parameter int START_GAP = 2,
  parameter int CYC_W     = 12,
  parameter int TIMEOUT   = 4000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  output logic [3:0]       X,
  output logic [3:0]       Y,
  output logic             valid,
  input  logic             DONE,
  input  logic [3:0]       C1X,
  input  logic [3:0]       C1Y,
  input  logic [3:0]       C2X,
  input  logic [3:0]       C2Y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_c1x,
  output logic [3:0]       res_c1y,
  output logic [3:0]       res_c2x,
  output logic [3:0]       res_c2y,
  output logic [CYC_W-1:0] res_cycles,
  output logic             res_timeout,
  output logic             busy
);

  localparam int AW = $clog2(NUM_PTS);
  localparam int RW = AW + 1;
  localparam int GW = $clog2(START_GAP + 1);

  localparam logic [AW-1:0]    W_LAST = AW'(NUM_PTS - 1);
  localparam logic [RW-1:0]    R_END  = RW'(NUM_PTS);
  localparam logic [CYC_W-1:0] T_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [GW-1:0]    G_LOAD = GW'(START_GAP - 1);

  feed_state_t state, state_nxt;

  logic [AW-1:0]    wptr;
  logic [RW-1:0]    rptr;
  logic [GW-1:0]    gap_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic             accept, fill_end, gap_end, send_end;
  logic             got_done, timed_out, res_take;
  point_t           wd, rd;

  assign wd = {in_y, in_x};

  laser_pt_buf #(
    .NUM_PTS (NUM_PTS),
    .AW      (AW)
  ) u_buf (
    .CLK   (CLK),
    .we    (accept),
    .waddr (wptr),
    .wdata (wd),
    .raddr (rptr[AW-1:0]),
    .rdata (rd)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fill_end  = 1'b0;
    gap_end   = 1'b0;
    send_end  = 1'b0;
    got_done  = 1'b0;
    timed_out = 1'b0;
    res_take  = 1'b0;
    unique case (state)
      FILL: begin
        accept   = in_valid && in_ready;
        fill_end = accept && (wptr == W_LAST);
        if (fill_end) state_nxt = GAP;
      end
      GAP: begin
        gap_end = (gap_cnt == '0);
        if (gap_end) state_nxt = SEND;
      end
      SEND: begin
        send_end = (rptr == R_END);
        if (send_end) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        got_done  = DONE;
        timed_out = !DONE && (cyc_cnt == T_LAST);
        if (got_done || timed_out) state_nxt = REPORT;
      end
      REPORT: begin
        res_take = res_valid && res_ready;
        if (res_take) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      gap_cnt     <= '0;
      cyc_cnt     <= '0;
      X           <= '0;
      Y           <= '0;
      valid       <= 1'b0;
      res_valid   <= 1'b0;
      res_c1x     <= '0;
      res_c1y     <= '0;
      res_c2x     <= '0;
      res_c2y     <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      in_ready <= (state_nxt == FILL);
      busy     <= (state_nxt != FILL);
      if (accept) wptr <= wptr + 1'b1;
      if (fill_end) begin
        gap_cnt <= G_LOAD;
        rptr    <= '0;
      end
      if (state == GAP) begin
        if (gap_end) begin
          X     <= rd.x;
          Y     <= rd.y;
          valid <= 1'b1;
          rptr  <= RW'(1);
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
      // Final point stays on X/Y after valid drops
      if (state == SEND) begin
        if (send_end) begin
          valid   <= 1'b0;
          cyc_cnt <= '0;
        end else begin
          X    <= rd.x;
          Y    <= rd.y;
          rptr <= rptr + 1'b1;
        end
      end
      if (state == WAIT_DONE) begin
        if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
        if (got_done) begin
          res_c1x     <= C1X;
          res_c1y     <= C1Y;
          res_c2x     <= C2X;
          res_c2y     <= C2Y;
          res_cycles  <= cyc_cnt;
          res_timeout <= 1'b0;
          res_valid   <= 1'b1;
        end else if (timed_out) begin
          res_c1x     <= '0;
          res_c1y     <= '0;
          res_c2x     <= '0;
          res_c2y     <= '0;
          res_cycles  <= T_LAST;
          res_timeout <= 1'b1;
          res_valid   <= 1'b1;
        end
      end
      if (res_take) begin
        res_valid <= 1'b0;
        wptr      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_laser_point_feeder.sv
// Randomized bench for laser_point_feeder against a frame/result model.
// Model: expected stream is the accepted-point queue; results from DONE timing.
module tb_laser_point_feeder;

  localparam int NP = 40;
  localparam int SG = 2;
  localparam int CW = 12;
  localparam int TO = 4000;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid, in_ready;
  logic [3:0]    in_x, in_y, X, Y;
  logic          valid, DONE;
  logic [3:0]    C1X, C1Y, C2X, C2Y;
  logic          res_valid, res_ready;
  logic [3:0]    res_c1x, res_c1y, res_c2x, res_c2y;
  logic [CW-1:0] res_cycles;
  logic          res_timeout, busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] frame [NP];
  logic [7:0] q [$];
  bit tied = 1'b0;

  laser_point_feeder #(
    .NUM_PTS   (NP),
    .START_GAP (SG),
    .CYC_W     (CW),
    .TIMEOUT   (TO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .X           (X),
    .Y           (Y),
    .valid       (valid),
    .DONE        (DONE),
    .C1X         (C1X),
    .C1Y         (C1Y),
    .C2X         (C2X),
    .C2Y         (C2Y),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_c1x     (res_c1x),
    .res_c1y     (res_c1y),
    .res_c2x     (res_c2x),
    .res_c2y     (res_c2y),
    .res_cycles  (res_cycles),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mk_frame(input bit pattern);
    for (int i = 0; i < NP; i++)
      frame[i] = pattern ? {4'(i / 16), 4'(i % 16)} : 8'($urandom);
  endtask

  task automatic load_frame(input bit gaps, input bit stray);
    int i = 0;
    int n = 0;
    int drops = 0;
    bit acc;
    q.delete();
    chk("ready_at_start", {31'd0, in_ready}, 1);
    while (i < NP && n < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_x = frame[i][3:0];
      in_y = frame[i][7:4];
      DONE = stray ? ($urandom_range(0, 4) == 0) : 1'b0;
      if (!in_ready) drops++;
      acc = in_valid && in_ready;
      tick();
      n++;
      if (acc) begin
        q.push_back(frame[i]);
        i++;
      end
    end
    in_valid = 1'b0;
    DONE = 1'b0;
    chk("fill_drops", drops, 0);
    chk("fill_count", i, NP);
    chk("ready_after_fill", {31'd0, in_ready}, 0);
    chk("busy_after_fill", {31'd0, busy}, 1);
    chk("no_res_in_fill", {31'd0, res_valid}, 0);
  endtask

  task automatic stream(input int abort_at);
    int n = 1;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
    chk("start_latency", n, SG + 1);
    for (int j = 0; j < NP; j++) begin
      if (j == abort_at) begin
        RST = 1'b1;
        #1;
        chk("rst_valid_drop", {31'd0, valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        repeat (2) tick();
        chk("rst_ready_low", {31'd0, in_ready}, 0);
        RST = 1'b0;
        #1;
        chk("ready_at_release", {31'd0, in_ready}, 0);
        tick();
        chk("ready_after_rst", {31'd0, in_ready}, 1);
        chk("res_after_rst", {31'd0, res_valid}, 0);
        return;
      end
      chk("stream_valid", {31'd0, valid}, 1);
      chk("stream_pt", {24'd0, Y, X}, {24'd0, q[j]});
      tick();
    end
    chk("valid_drop", {31'd0, valid}, 0);
    chk("hold_xy", {24'd0, Y, X}, {24'd0, q[NP-1]});
  endtask

  task automatic get_result(input int delay, input bit to, input int hold,
                            input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    int early = 0;
    int n = 0;
    logic [3:0] e [4];
    int ecyc;
    C1X = 4'($urandom_range(1, 15));
    C1Y = 4'($urandom_range(1, 15));
    C2X = 4'($urandom_range(1, 15));
    C2Y = 4'($urandom_range(1, 15));
    if (!to) begin
      repeat (delay - 1) begin
        if (res_valid) early++;
        tick();
      end
      if (res_valid) early++;
      C1X = a; C1Y = b; C2X = c; C2Y = d;
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      chk("early_res", early, 0);
      e[0] = a; e[1] = b; e[2] = c; e[3] = d;
      ecyc = delay - 1;
    end else begin
      while (!res_valid && n < TO + 50) begin
        tick();
        n++;
      end
      chk("timeout_latency", n, TO);
      e[0] = 0; e[1] = 0; e[2] = 0; e[3] = 0;
      ecyc = TO - 1;
    end
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) res_ready = 1'b1;
      chk("res_valid", {31'd0, res_valid}, 1);
      chk("res_c1x", {28'd0, res_c1x}, {28'd0, e[0]});
      chk("res_c1y", {28'd0, res_c1y}, {28'd0, e[1]});
      chk("res_c2x", {28'd0, res_c2x}, {28'd0, e[2]});
      chk("res_c2y", {28'd0, res_c2y}, {28'd0, e[3]});
      chk("res_cycles", {20'd0, res_cycles}, ecyc);
      chk("res_timeout", {31'd0, res_timeout}, {31'd0, to});
      tick();
    end
    res_ready = tied;
    chk("res_cleared", {31'd0, res_valid}, 0);
    chk("ready_after_res", {31'd0, in_ready}, 1);
    chk("busy_after_res", {31'd0, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_xy", {24'd0, Y, X}, 0);
    chk("rst_timeout", {31'd0, res_timeout}, 0);
    RST = 1'b0;
    tick();
    chk("ready_first_edge", {31'd0, in_ready}, 1);

    mk_frame(1'b1);
    load_frame(1'b0, 1'b0);
    stream(-1);
    get_result(150, 1'b0, 4, 4'd5, 4'd7, 4'd10, 4'd3);

    mk_frame(1'b0);
    load_frame(1'b0, 1'b0);
    stream(-1);
    get_result(0, 1'b1, 2, 4'd0, 4'd0, 4'd0, 4'd0);

    mk_frame(1'b0);
    load_frame(1'b1, 1'b1);
    stream(-1);
    get_result($urandom_range(1, 300), 1'b0, $urandom_range(0, 5),
               4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));

    mk_frame(1'b0);
    load_frame(1'b0, 1'b0);
    stream(19);
    mk_frame(1'b0);
    load_frame(1'b1, 1'b0);
    stream(-1);
    get_result(1, 1'b0, 1, 4'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom));

    tied = 1'b1;
    res_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      mk_frame(1'b0);
      load_frame(1'b0, 1'b0);
      stream(-1);
      get_result($urandom_range(2, 60), 1'b0, 0, 4'($urandom),
                 4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/laser_point_feeder.md
Name: laser_point_feeder

Overview:
- Transmit-side partner of the two-circle laser placement engine.
- Buffers one frame of NUM_PTS target points from an upstream loader, then streams them to the engine over its X/Y/valid input, one per cycle.
- Waits for the engine's DONE and captures C1X/C1Y/C2X/C2Y, then returns them with a cycle count over a valid/ready result port.
- Shares CLK and RST with the engine.

Parameters:
- NUM_PTS, 40: points per frame; must equal the engine's frame size.
- START_GAP, 2: idle cycles between the last buffered point and the first valid; minimum 1.
- CYC_W, 12: width of the DONE-latency counter.
- TIMEOUT, 4000: cycles to wait for DONE before abort; must be less than 2^CYC_W.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- in_valid  in  1  upstream point valid
- in_ready  out  1  feeder accepts a point
- in_x  in  4  point X
- in_y  in  4  point Y
- X  out  4  point X to engine
- Y  out  4  point Y to engine
- valid  out  1  point strobe to engine
- DONE  in  1  engine result strobe
- C1X, C1Y, C2X, C2Y  in  4 each  engine circle centres
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_c1x, res_c1y, res_c2x, res_c2y  out  4 each  captured centres
- res_cycles  out  CYC_W  cycles from last valid to DONE
- res_timeout  out  1  DONE never arrived
- busy  out  1  high in every state except FILL

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high, RST.
- All outputs are registered and reset to 0. The state machine resets to FILL. in_ready is 0 while RST is high and rises at the first CLK edge after deassertion.
- FILL:
  - in_ready = 1.
  - On in_valid && in_ready, write {in_y, in_x} to buf[wptr], then wptr++.
  - When the accept has wptr == NUM_PTS-1, clear in_ready at the same edge and go to GAP with gap_cnt = START_GAP-1.
- GAP:
  - Decrement gap_cnt each cycle.
  - When gap_cnt == 0, load X/Y = buf[0], set valid = 1, rptr = 1, and go to SEND.
- SEND:
  - valid stays high for exactly NUM_PTS consecutive cycles. X/Y follow arrival order, one point per cycle.
  - At the edge after the final point, drop valid to 0 and hold X/Y at the final point.
  - Clear cyc_cnt and go to WAIT_DONE.
- WAIT_DONE:
  - cyc_cnt increments each cycle, saturating at all-ones.
  - On DONE == 1, capture C1X/C1Y/C2X/C2Y into res_c*, set res_cycles = cyc_cnt and res_timeout = 0, set res_valid = 1, and go to REPORT.
  - If cyc_cnt == TIMEOUT-1 and DONE == 0, set res_c* = 0, res_cycles = TIMEOUT-1, res_timeout = 1, res_valid = 1, and go to REPORT.
  - DONE and timeout in the same cycle: DONE wins.
- REPORT:
  - Hold res_* stable until res_valid && res_ready.
  - At that edge, clear res_valid, set wptr = 0, set in_ready = 1, and return to FILL.
  - res_c*/res_cycles keep their values until the next capture.
- DONE outside WAIT_DONE is ignored. in_valid outside FILL is ignored; in_ready is 0 there.
- Minimum latency: the first valid is the (START_GAP+1)th cycle after the last accepted point.
- Reset mid-frame discards the buffer and any pending result, and drops valid immediately.
- The buffer is not cleared on frame completion. A frame is always fully rewritten before it is sent.

Decomposition:
- Shared package laser_pkg:
  - COORD_W = 4
  - NUM_PTS_DEF = 40
  - point typedef {y[3:0], x[3:0]}, 8 bits, identical to the engine's internal packing
  - feeder state enum: FILL, GAP, SEND, WAIT_DONE, REPORT
- One sub-module, laser_pt_buf:
  - NUM_PTS x 8 register file
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata)
  - no reset on the storage array

Test Plan:
- Reset, then load 40 points (x = i%16, y = i/16 for i = 0..39) at full rate. Expect: in_ready falls after the 40th; valid rises 3 cycles later; 40 consecutive valid cycles with X/Y matching order.
- Model engine asserts DONE 150 cycles after the last valid with C1 = (5,7), C2 = (10,3), and res_ready is held 0 for 4 cycles. Expect: res_valid stable with res_c1x=5, res_c1y=7, res_c2x=10, res_c2y=3, res_cycles=149, res_timeout=0 until the handshake.
- DONE never asserted. Expect: res_valid after 4000 cycles with res_timeout=1, res_cycles=3999, and all res_c* = 0.
- Upstream inserts random in_valid gaps and the model pulses DONE during FILL. Expect: all 40 points stored in order, no early transition, and the stray DONE ignored.
- Assert RST on the 20th valid of SEND. Expect: valid=0 immediately, in_ready=1 one edge after RST is released, and the next full frame streams correctly from point 0.
- Back-to-back frames with res_ready tied 1. Expect: the second frame's points are accepted starting the cycle after the first result handshake, and both results are correct.
